// File: rtl/wi23_defs.sv
// Shared WI23 instruction-memory geometry and opcode encoding.
package wi23_defs;

  localparam int IMEM_DEPTH = 8;
  localparam int IMEM_WIDTH = 16;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 11;
  localparam logic [OPC_MSB-OPC_LSB:0] OPC_HALT = 5'b11111;

  function automatic logic is_halt(input logic [IMEM_WIDTH-1:0] inst);
    return inst[OPC_MSB:OPC_LSB] == OPC_HALT;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Two-entry buffer between fetch and decode; zero-latency head, synchronous flush.
module ifetch_fifo #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] din_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_q, rd_q;
  logic [1:0]   cnt_q, cnt_d;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign head_o  = mem_q[rd_q];

  always_comb begin
    cnt_d = cnt_q;
    if (push_i && !pop_i)      cnt_d = cnt_q + 2'd1;
    else if (!push_i && pop_i) cnt_d = cnt_q - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 2'd0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
    end else if (flush_i) begin
      cnt_q <= 2'd0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (push_i) wr_q <= ~wr_q;
      if (pop_i)  rd_q <= ~rd_q;
    end
  end

  // Payload needs no reset: it is only observed through a nonzero count.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: registered PC, 2-entry fetch buffer, redirect, optional HALT stop.
// Optional feature: define IFETCH_HALT_DETECT_EN to stop fetching after a HALT opcode.
module ifetch
  import wi23_defs::*;
#(
  parameter logic [IMEM_DEPTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [IMEM_DEPTH-1:0] addr_o,
  input  logic [IMEM_WIDTH-1:0] inst_i,
  input  logic                  redirect_i,
  input  logic [IMEM_DEPTH-1:0] redirect_pc_i,
  output logic [IMEM_WIDTH-1:0] inst_o,
  output logic [IMEM_DEPTH-1:0] pc_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  halted_o
);

  logic [IMEM_DEPTH-1:0]            pc_q, pc_d;
  logic                             fifo_full, fifo_empty;
  logic                             push, pop, halted;
  logic [IMEM_WIDTH+IMEM_DEPTH-1:0] head;

  assign valid_o = !fifo_empty;
  assign pop     = valid_o && ready_i && !redirect_i;
  // A full buffer still accepts a new word when its head leaves in the same cycle.
  assign push    = (!fifo_full || pop) && !halted && !redirect_i;

  always_comb begin
    pc_d = pc_q;
    if (redirect_i) pc_d = redirect_pc_i;
    else if (push)  pc_d = pc_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

`ifdef IFETCH_HALT_DETECT_EN
  logic halted_q, halted_d;

  always_comb begin
    halted_d = halted_q;
    if (redirect_i)                   halted_d = 1'b0;
    else if (push && is_halt(inst_i)) halted_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) halted_q <= 1'b0;
    else        halted_q <= halted_d;
  end

  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  assign halted_o = halted;
  assign addr_o   = pc_q;
  assign inst_o   = head[IMEM_WIDTH+IMEM_DEPTH-1:IMEM_DEPTH];
  assign pc_o     = head[IMEM_DEPTH-1:0];

  ifetch_fifo #(.W(IMEM_WIDTH + IMEM_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .din_i   ({inst_i, pc_q}),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head)
  );

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed scenarios plus a randomized stream scored against a transaction model.
module tb_ifetch;
  import wi23_defs::*;

  localparam logic [IMEM_DEPTH-1:0] PC_B = '1;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  ready, redirect;
  logic [IMEM_DEPTH-1:0] rpc;
  logic [IMEM_DEPTH-1:0] addr_a, addr_b, pc_a, pc_b;
  logic [IMEM_WIDTH-1:0] inst_ia, inst_ib, inst_a, inst_b;
  logic                  valid_a, valid_b, halted_a, halted_b;

  logic [IMEM_WIDTH-1:0] mem [2**IMEM_DEPTH];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Synchronous-read memory: word at the current address is presented at the negedge.
  always @(negedge clk) begin
    inst_ia = mem[addr_a];
    inst_ib = mem[addr_b];
  end

  ifetch #(.RESET_PC('0)) dut_a (
    .clk(clk), .rst_n(rst_n), .addr_o(addr_a), .inst_i(inst_ia),
    .redirect_i(redirect), .redirect_pc_i(rpc), .inst_o(inst_a), .pc_o(pc_a),
    .valid_o(valid_a), .ready_i(ready), .halted_o(halted_a)
  );

  ifetch #(.RESET_PC(PC_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .addr_o(addr_b), .inst_i(inst_ib),
    .redirect_i(redirect), .redirect_pc_i(rpc), .inst_o(inst_b), .pc_o(pc_b),
    .valid_o(valid_b), .ready_i(ready), .halted_o(halted_b)
  );

  task automatic fill_linear();
    for (int i = 0; i < 2**IMEM_DEPTH; i++) mem[i] = IMEM_WIDTH'(i);
  endtask

  task automatic fill_random();
    logic [IMEM_WIDTH-1:0] v;
    for (int i = 0; i < 2**IMEM_DEPTH; i++) begin
      v = IMEM_WIDTH'($urandom);
      if (v[OPC_MSB:OPC_LSB] == OPC_HALT) v[OPC_MSB] = 1'b0;
      mem[i] = v;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ready = 1'b0; redirect = 1'b0; rpc = '0;
    fill_linear();
    repeat (2) @(negedge clk);
    n_cmp++; if (valid_a !== 1'b0) begin n_bad++; $display("FAIL reset_valid_a got %b want 0", valid_a); end
    n_cmp++; if (valid_b !== 1'b0) begin n_bad++; $display("FAIL reset_valid_b got %b want 0", valid_b); end
    n_cmp++; if (halted_a !== 1'b0) begin n_bad++; $display("FAIL reset_halted got %b want 0", halted_a); end
    n_cmp++; if (addr_a !== '0) begin n_bad++; $display("FAIL reset_addr_a got %h want 00", addr_a); end
    n_cmp++; if (addr_b !== PC_B) begin n_bad++; $display("FAIL reset_addr_b got %h want %h", addr_b, PC_B); end
  endtask

  // Release reset with ready high: one word per cycle from RESET_PC, including all-ones wrap.
  task automatic test_sequential();
    logic [IMEM_DEPTH-1:0] eb;
    ready = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (valid_a !== 1'b1 || pc_a !== IMEM_DEPTH'(i) || inst_a !== IMEM_WIDTH'(i)) begin
        n_bad++; $display("FAIL seq_a[%0d] got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h", i, valid_a, pc_a, inst_a, i[7:0], i[15:0]);
      end
      n_cmp++; if (addr_a !== IMEM_DEPTH'(i + 1)) begin
        n_bad++; $display("FAIL seq_addr[%0d] got %h want %h", i, addr_a, i + 1);
      end
      if (i < 3) begin
        eb = PC_B + IMEM_DEPTH'(i);
        n_cmp++; if (valid_b !== 1'b1 || pc_b !== eb || inst_b !== IMEM_WIDTH'(eb)) begin
          n_bad++; $display("FAIL wrap_b[%0d] got v=%b pc=%h inst=%h want v=1 pc=%h", i, valid_b, pc_b, inst_b, eb);
        end
      end
    end
  endtask

  task automatic test_stall();
    bit found = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (valid_a && pc_a == IMEM_DEPTH'(5)) begin found = 1; break; end
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL stall_find_pc5 got none want pc_o=05 within 20 cycles"); end
    ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      n_cmp++; if (valid_a !== 1'b1 || pc_a !== 8'h05 || inst_a !== 16'h0005) begin
        n_bad++; $display("FAIL stall_hold[%0d] got v=%b pc=%h inst=%h want v=1 pc=05 inst=0005", j, valid_a, pc_a, inst_a);
      end
      n_cmp++; if (addr_a !== 8'h07) begin n_bad++; $display("FAIL stall_addr[%0d] got %h want 07", j, addr_a); end
    end
    ready = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      n_cmp++; if (valid_a !== 1'b1 || pc_a !== IMEM_DEPTH'(5 + j)) begin
        n_bad++; $display("FAIL stall_resume[%0d] got v=%b pc=%h want v=1 pc=%h", j, valid_a, pc_a, 5 + j);
      end
    end
  endtask

  task automatic test_redirect_full();
    ready = 1'b0;
    repeat (3) @(negedge clk);
    redirect = 1'b1; rpc = 8'h40; ready = 1'b1;
    @(negedge clk);
    redirect = 1'b0;
    n_cmp++; if (valid_a !== 1'b0) begin n_bad++; $display("FAIL redir_flush got v=%b pc=%h want v=0", valid_a, pc_a); end
    n_cmp++; if (addr_a !== 8'h40) begin n_bad++; $display("FAIL redir_addr got %h want 40", addr_a); end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      n_cmp++; if (valid_a !== 1'b1 || pc_a !== IMEM_DEPTH'(8'h40 + j) || inst_a !== IMEM_WIDTH'(8'h40 + j)) begin
        n_bad++; $display("FAIL redir_seq[%0d] got v=%b pc=%h inst=%h want v=1 pc=%h", j, valid_a, pc_a, inst_a, 8'h40 + j);
      end
    end
  endtask

  // Transaction model: accepted words form a consecutive address run from the last redirect
  // target, each carrying mem[pc]; stalled heads hold; a ready consumer sees no bubbles.
  task automatic test_random_stream(input int n);
    logic [IMEM_DEPTH-1:0] exp_pc, hold_pc;
    logic [IMEM_WIDTH-1:0] hold_inst;
    bit prev_hold = 0, prev_ready = 0, prev_valid = 0, prev_redir = 1, redir;
    int xfers = 0;
    fill_random();
    redirect = 1'b1; rpc = IMEM_DEPTH'($urandom); ready = 1'b0;
    exp_pc = rpc;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      n_cmp++; if (halted_a !== 1'b0) begin n_bad++; $display("FAIL rnd_halted[%0d] got %b want 0", c, halted_a); end
      if (prev_hold) begin
        n_cmp++; if (valid_a !== 1'b1 || pc_a !== hold_pc || inst_a !== hold_inst) begin
          n_bad++; $display("FAIL rnd_stable[%0d] got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h", c, valid_a, pc_a, inst_a, hold_pc, hold_inst);
        end
      end
      if (prev_ready && prev_valid && !prev_redir) begin
        n_cmp++; if (valid_a !== 1'b1) begin n_bad++; $display("FAIL rnd_bubble[%0d] got v=%b want 1", c, valid_a); end
      end
      redir = ($urandom_range(0, 19) == 0);
      if (redir) begin
        redirect = 1'b1; rpc = IMEM_DEPTH'($urandom); ready = 1'($urandom);
        exp_pc = rpc;
      end else begin
        redirect = 1'b0;
        ready = ($urandom_range(0, 3) != 0);
        if (valid_a && ready) begin
          n_cmp++; if (pc_a !== exp_pc || inst_a !== mem[exp_pc]) begin
            n_bad++; $display("FAIL rnd_xfer[%0d] got pc=%h inst=%h want pc=%h inst=%h", c, pc_a, inst_a, exp_pc, mem[exp_pc]);
          end
          exp_pc = exp_pc + 1'b1;
          xfers++;
        end
      end
      prev_hold  = valid_a && !ready && !redir;
      hold_pc    = pc_a;
      hold_inst  = inst_a;
      prev_ready = ready;
      prev_valid = valid_a;
      prev_redir = redir;
    end
    redirect = 1'b0;
    n_cmp++; if (xfers < n / 4) begin n_bad++; $display("FAIL rnd_progress got %0d transfers want >= %0d", xfers, n / 4); end
  endtask

  task automatic test_midstream_reset();
    ready = 1'b1; redirect = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (valid_a !== 1'b1) begin n_bad++; $display("FAIL mrst_pre_valid got %b want 1", valid_a); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (valid_a !== 1'b0 || valid_b !== 1'b0) begin
      n_bad++; $display("FAIL mrst_valid_drop got a=%b b=%b want 0 0", valid_a, valid_b);
    end
    n_cmp++; if (addr_a !== '0 || addr_b !== PC_B) begin
      n_bad++; $display("FAIL mrst_addr got a=%h b=%h want 00 %h", addr_a, addr_b, PC_B);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      n_cmp++; if (valid_a !== 1'b1 || pc_a !== IMEM_DEPTH'(j) || inst_a !== mem[j]) begin
        n_bad++; $display("FAIL mrst_restart[%0d] got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h", j, valid_a, pc_a, inst_a, j, mem[j]);
      end
    end
  endtask

`ifdef IFETCH_HALT_DETECT_EN
  task automatic test_halt();
    rst_n = 1'b0; ready = 1'b1; redirect = 1'b0;
    fill_linear();
    mem[3][OPC_MSB:OPC_LSB] = OPC_HALT;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (valid_a !== 1'b1 || pc_a !== IMEM_DEPTH'(i) || inst_a !== mem[i]) begin
        n_bad++; $display("FAIL halt_seq[%0d] got v=%b pc=%h inst=%h want v=1 pc=%h", i, valid_a, pc_a, inst_a, i);
      end
    end
    for (int j = 0; j < 3; j++) begin
      n_cmp++; if (halted_a !== 1'b1 || addr_a !== 8'h04) begin
        n_bad++; $display("FAIL halt_stop[%0d] got h=%b addr=%h want h=1 addr=04", j, halted_a, addr_a);
      end
      @(negedge clk);
      n_cmp++; if (valid_a !== 1'b0) begin n_bad++; $display("FAIL halt_drain[%0d] got v=%b want 0", j, valid_a); end
    end
    redirect = 1'b1; rpc = '0;
    @(negedge clk);
    redirect = 1'b0;
    n_cmp++; if (halted_a !== 1'b0 || addr_a !== '0) begin
      n_bad++; $display("FAIL halt_clear got h=%b addr=%h want h=0 addr=00", halted_a, addr_a);
    end
    @(negedge clk);
    n_cmp++; if (valid_a !== 1'b1 || pc_a !== '0) begin
      n_bad++; $display("FAIL halt_resume got v=%b pc=%h want v=1 pc=00", valid_a, pc_a);
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog expired got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_full();
    test_random_stream(400);
    test_midstream_reset();
`ifdef IFETCH_HALT_DETECT_EN
    test_halt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 0, meaning the word address fetched first after reset.
REQ-002 SHALL have port clk  input  1  single clock, all state on posedge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port addr_o  output  IMEM_DEPTH  instruction word address to the instruction memory.
REQ-005 SHALL have port inst_i  input  IMEM_WIDTH  instruction word from memory, read at the preceding negedge.
REQ-006 SHALL have port redirect_i  input  1  branch/jump redirect strobe.
REQ-007 SHALL have port redirect_pc_i  input  IMEM_DEPTH  redirect target word address.
REQ-008 SHALL have port inst_o  output  IMEM_WIDTH  instruction presented to decode.
REQ-009 SHALL have port pc_o  output  IMEM_DEPTH  word address of inst_o.
REQ-010 SHALL have port valid_o  output  1  inst_o/pc_o valid.
REQ-011 SHALL have port ready_i  input  1  decode accepts; transfer occurs when valid_o && ready_i at posedge.
REQ-012 SHALL have port halted_o  output  1  fetch stopped on HALT (see Configuration).

Function
REQ-013 SHALL hold a PC register pc_r driving addr_o directly (no combinational path from any input to addr_o).
REQ-014 SHALL treat inst_i at a posedge as the memory word at the addr_o value driven during that cycle.
REQ-015 SHALL buffer fetched {inst, pc} pairs in a 2-entry FIFO; head drives inst_o/pc_o; valid_o = FIFO not empty.
REQ-016 SHALL push {inst_i, pc_r} and increment pc_r when FIFO not full, or full with a pop in the same cycle, and not halted; otherwise hold pc_r.
REQ-017 SHALL increment pc_r modulo 2^IMEM_DEPTH (all-ones wraps to 0, no flag).
REQ-018 SHALL pop the head when valid_o && ready_i.
REQ-019 SHALL, on redirect_i at posedge, load pc_r <= redirect_pc_i, flush the FIFO, clear halted_o, and suppress that cycle's push and pop; redirect has priority over every other event.
REQ-020 SHALL have a latency of one cycle: an instruction addressed in cycle N appears on inst_o with valid_o in cycle N+1 when the FIFO was empty.
REQ-021 SHALL sustain one instruction per cycle while ready_i is held high.
REQ-022 SHALL keep inst_o/pc_o stable while valid_o && !ready_i.

Reset
REQ-023 SHALL, on rst_n low, asynchronously set pc_r=RESET_PC, FIFO empty, valid_o=0, halted_o=0; inst_o/pc_o are don't-care while valid_o=0.
REQ-024 SHALL, on reset asserted mid-operation, discard all buffered instructions, with the first fetch after release at RESET_PC.

Configuration
REQ-025 SHALL, with IFETCH_HALT_DETECT_EN defined, set halted_o and stop pushing/incrementing after pushing an instruction whose opcode field equals OPC_HALT; buffered instructions still drain; only redirect or reset resumes.
REQ-026 SHALL, without IFETCH_HALT_DETECT_EN, tie halted_o to 0 and never stop fetching.

Structure
REQ-027 SHALL take IMEM_DEPTH, IMEM_WIDTH, OPC_HALT, and the opcode field position from the shared wi23_defs package.
REQ-028 SHALL place the 2-entry FIFO in a sub-module ifetch_fifo (push, pop, flush, full, empty, head data).

Verification
REQ-029 SHALL cover: reset release, ready_i=1, memory holds addr value at each addr -> pc_o 0,1,2,3 on consecutive cycles starting one cycle after release.
REQ-030 SHALL cover: ready_i low 3 cycles from pc_o=5 -> pc_o stays 5, addr_o stalls at 7, no loss/duplication after ready_i returns.
REQ-031 SHALL cover: redirect_i with redirect_pc_i=0x40 while FIFO full -> next valid pc_o=0x40, no stale entries.
REQ-032 SHALL cover: RESET_PC = all-ones -> pc_o sequence all-ones, 0, 1.
REQ-033 SHALL cover, with IFETCH_HALT_DETECT_EN: HALT at addr 3 -> pc_o 0..3 delivered, halted_o=1, addr_o fixed at 4; redirect to 0 clears halted_o.
REQ-034 SHALL cover: rst_n pulsed low mid-stream between clock edges -> valid_o drops immediately, fetch restarts at RESET_PC.
